// File: rtl/bin_to_bcd_display.sv
// rtl/bin_to_bcd_display.sv - 14-bit binary to 4-digit BCD converter for the display driver.
// Optional: define BCD_SATURATE_EN to show 9999 when the input exceeds 9999.
module bin_to_bcd_display (
    input  logic        Clk,
    input  logic        reset,
    input  logic        start,
    input  logic [13:0] bin_in,
    output logic        busy,
    output logic        done,
    output logic        overflow,
    output logic [3:0]  SEG3,
    output logic [3:0]  SEG2,
    output logic [3:0]  SEG1,
    output logic [3:0]  SEG0
);

    typedef enum logic {IDLE, CONVERT} state_t;

    localparam logic [3:0]  LAST_ITER = 4'd13;
    localparam logic [13:0] MAX_BCD   = 14'd9999;

    state_t      state_q, state_d;
    logic [3:0]  cnt_q, cnt_d;
    logic [13:0] cap_q, cap_d;
    logic [13:0] shift_q, shift_d;
    logic [15:0] scratch_q, scratch_d;
    logic [15:0] seg_q, seg_d;
    logic        busy_q, busy_d;
    logic        done_q, done_d;
    logic        ovf_q, ovf_d;

    logic [15:0] adjusted;
    logic [15:0] shifted;
    logic        is_over;

    function automatic logic [15:0] dabble_adjust(input logic [15:0] s);
        logic [15:0] r;
        r = s;
        for (int i = 0; i < 4; i++) begin
            if (s[4*i +: 4] >= 4'd5)
                r[4*i +: 4] = s[4*i +: 4] + 4'd3;
        end
        return r;
    endfunction

    // The thousands digit's carry bit falls off the top, so the result is bin mod 10000.
    assign adjusted = dabble_adjust(scratch_q);
    assign shifted  = {adjusted[14:0], shift_q[13]};
    assign is_over  = (cap_q > MAX_BCD);

    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        cap_d     = cap_q;
        shift_d   = shift_q;
        scratch_d = scratch_q;
        seg_d     = seg_q;
        busy_d    = busy_q;
        ovf_d     = ovf_q;
        done_d    = 1'b0;
        case (state_q)
            IDLE: begin
                if (start) begin
                    cap_d     = bin_in;
                    shift_d   = bin_in;
                    scratch_d = 16'h0000;
                    cnt_d     = 4'd0;
                    busy_d    = 1'b1;
                    state_d   = CONVERT;
                end
            end
            CONVERT: begin
                scratch_d = shifted;
                shift_d   = {shift_q[12:0], 1'b0};
                cnt_d     = cnt_q + 4'd1;
                if (cnt_q == LAST_ITER) begin
                    cnt_d   = 4'd0;
                    busy_d  = 1'b0;
                    done_d  = 1'b1;
                    ovf_d   = is_over;
                    state_d = IDLE;
`ifdef BCD_SATURATE_EN
                    seg_d   = is_over ? 16'h9999 : shifted;
`else
                    seg_d   = shifted;
`endif
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge Clk or posedge reset) begin
        if (reset) begin
            state_q   <= IDLE;
            cnt_q     <= 4'd0;
            cap_q     <= 14'd0;
            shift_q   <= 14'd0;
            scratch_q <= 16'h0000;
            seg_q     <= 16'h0000;
            busy_q    <= 1'b0;
            done_q    <= 1'b0;
            ovf_q     <= 1'b0;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            cap_q     <= cap_d;
            shift_q   <= shift_d;
            scratch_q <= scratch_d;
            seg_q     <= seg_d;
            busy_q    <= busy_d;
            done_q    <= done_d;
            ovf_q     <= ovf_d;
        end
    end

    assign busy     = busy_q;
    assign done     = done_q;
    assign overflow = ovf_q;
    assign SEG3     = seg_q[15:12];
    assign SEG2     = seg_q[11:8];
    assign SEG1     = seg_q[7:4];
    assign SEG0     = seg_q[3:0];

endmodule

// File: doc/bin_to_bcd_display.md
BIN_TO_BCD_DISPLAY -- requirements
Module: bin_to_bcd_display

Interface
REQ-001 Parameters SHALL be none; all widths are fixed.
REQ-002 Clk  input  1  sole clock; all state changes on rising edge.
REQ-003 reset  input  1  asynchronous, active-high reset.
REQ-004 start  input  1  conversion request, sampled on Clk rising edge.
REQ-005 bin_in  input  14  unsigned binary value, sampled only on the accepting edge.
REQ-006 busy  output  1  high while a conversion is in progress.
REQ-007 done  output  1  one-cycle pulse marking new result valid.
REQ-008 overflow  output  1  registered flag: last accepted bin_in > 9999.
REQ-009 SEG3  output  4  thousands BCD digit, most significant, feeds the display driver.
REQ-010 SEG2  output  4  hundreds BCD digit.
REQ-011 SEG1  output  4  tens BCD digit.
REQ-012 SEG0  output  4  ones BCD digit, least significant.

Function
REQ-013 The FSM SHALL have exactly two states, IDLE and CONVERT, and a 4-bit iteration counter.
REQ-014 In IDLE with start=1 at edge E0, the block SHALL capture bin_in, clear the 16-bit BCD scratch, set the counter to 0, and enter CONVERT.
REQ-015 Each CONVERT edge SHALL perform one double-dabble iteration: add 3 to every scratch digit >= 5, then shift {scratch, shift_reg} left by 1.
REQ-016 On the 14th CONVERT edge (E14, counter = 13), the block SHALL load SEG3..SEG0 and overflow, assert done for the following cycle, and return to IDLE.
REQ-017 busy SHALL be 1 from after E0 through E14 (14 cycles) and 0 otherwise.
REQ-018 Latency SHALL be fixed: start sampled at E0 -> done high and SEG valid in the cycle after E14.
REQ-019 done SHALL be high for exactly one cycle per conversion and never while busy=1.
REQ-020 start while busy=1 SHALL be ignored, with no queuing and no effect on the running conversion.
REQ-021 start=1 in the cycle where done=1 (state IDLE) SHALL be accepted as a new conversion.
REQ-022 SEG3..SEG0 and overflow SHALL hold their previous values during CONVERT, changing only at E14.
REQ-023 The scratch register SHALL discard bits shifted out of the thousands digit, giving bin_in mod 10000 in the raw result.
REQ-024 overflow SHALL be computed as a 14-bit compare of the captured value against 9999.
REQ-025 All outputs SHALL be registered, with no combinational path from inputs to outputs.

Reset
REQ-026 reset=1 SHALL immediately force IDLE, counter=0, busy=0, done=0, overflow=0, and SEG3..SEG0=0 (display shows "0000").
REQ-027 reset asserted mid-conversion SHALL abort it, and no done SHALL follow.
REQ-028 After reset deasserts, the first start SHALL be accepted on the next edge.

Configuration
REQ-029 The macro BCD_SATURATE_EN SHALL select overflow handling at compile time.
REQ-030 With BCD_SATURATE_EN defined and overflow=1, SEG3..SEG0 SHALL load 9,9,9,9.
REQ-031 Without BCD_SATURATE_EN, SEG3..SEG0 SHALL load the raw mod-10000 digits.
REQ-032 In both configurations, overflow SHALL be reported identically.

Verification
REQ-033 bin_in=0, start pulse -> after 15 cycles done=1, SEG3..0=0,0,0,0, overflow=0.
REQ-034 bin_in=1234 at E0 -> busy high for 14 cycles, done in cycle 15, SEG3..0=1,2,3,4; bin_in=9999 -> 9,9,9,9, overflow=0.
REQ-035 bin_in=16383 -> overflow=1; SEG=9,9,9,9 with BCD_SATURATE_EN, 6,3,8,3 without; bin_in=10000 -> 9,9,9,9 or 0,0,0,0 respectively.
REQ-036 Start 1234, then start with bin_in=42 held during busy -> single done, SEG=1,2,3,4; start=1 in done cycle with bin_in=42 -> second done 15 cycles later, SEG=0,0,4,2.
REQ-037 Convert 5678, then start 1111 and assert reset at E7 -> SEG=0,0,0,0, busy=0, no done; next start with 0321 -> SEG=0,3,2,1.
